frame_scan_ctrl: RTL and testbench

- Read-side controller for the camera frame buffer (dual-port RAM, 160x120 RGB444, filled by the camera capture path).
- On a start request, it sequences a full-frame sweep of the buffer read port and classifies every pixel as red-, green- or blue-dominant.
- It accumulates the per-class counts and publishes counts plus a dominant-colour code for the SoC/software side.
- It runs entirely in the read-clock domain and drives the RAM read address.

---
 rtl/frame_scan_ctrl_if.sv | 26 ++
 rtl/frame_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_frame_scan_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scan_ctrl_if.sv
// Bus between the frame-scan controller, the frame-buffer read port and the SoC result registers.
// The master side drives start and read data; the slave side is the controller.
interface frame_scan_ctrl_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 12
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] count_red;
  logic [AW-1:0] count_green;
  logic [AW-1:0] count_blue;
  logic [1:0]    dominant;

  modport master (
    output start, mem_data,
    input  busy, done, mem_addr, count_red, count_green, count_blue, dominant
  );

  modport slave (
    input  start, mem_data,
    output busy, done, mem_addr, count_red, count_green, count_blue, dominant
  );
endinterface

// File: rtl/frame_scan_ctrl.sv
// Sweeps the frame buffer once per start request, classifies each RGB444 pixel by colour
// dominance and publishes per-class counts plus a dominant-colour code.
module frame_scan_ctrl #(
  parameter int unsigned CAM_SCREEN_X = 160,
  parameter int unsigned CAM_SCREEN_Y = 120,
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 12,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned TH           = 2,
  parameter int unsigned MIN_COUNT    = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  frame_scan_ctrl_if.slave   bus
);

  localparam int unsigned   N        = CAM_SCREEN_X * CAM_SCREEN_Y;
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);
  localparam logic [AW-1:0] MinCnt   = AW'(MIN_COUNT);
  localparam logic [1:0]    LastDrn  = 2'(RD_LAT - 1);
  localparam logic [4:0]    Th5      = 5'(TH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [AW-1:0]     r_addr;
  logic [RD_LAT-1:0] r_vld;
  logic [1:0]        r_drain;
  logic [AW-1:0]     r_acc_r, r_acc_g, r_acc_b;
  logic [AW-1:0]     r_cnt_r, r_cnt_g, r_cnt_b;
  logic [1:0]        r_dom;

  logic [4:0]    w_r, w_g, w_b;
  logic          w_pix_vld, w_is_r, w_is_g, w_is_b;
  logic [AW-1:0] w_acc_r_d, w_acc_g_d, w_acc_b_d;
  logic [1:0]    w_dom;

  // Nibbles widened to 5 bits so adding the margin cannot overflow.
  assign w_r       = {1'b0, bus.mem_data[11:8]};
  assign w_g       = {1'b0, bus.mem_data[7:4]};
  assign w_b       = {1'b0, bus.mem_data[3:0]};
  assign w_pix_vld = r_vld[RD_LAT-1];
  assign w_is_r    = (w_r > w_g + Th5) && (w_r > w_b + Th5);
  assign w_is_g    = (w_g > w_r + Th5) && (w_g > w_b + Th5);
  assign w_is_b    = (w_b > w_r + Th5) && (w_b > w_g + Th5);

  assign w_acc_r_d = r_acc_r + {{(AW-1){1'b0}}, w_pix_vld & w_is_r};
  assign w_acc_g_d = r_acc_g + {{(AW-1){1'b0}}, w_pix_vld & w_is_g};
  assign w_acc_b_d = r_acc_b + {{(AW-1){1'b0}}, w_pix_vld & w_is_b};

  always_comb begin
    w_dom = 2'd0;
    if (w_acc_r_d > w_acc_g_d && w_acc_r_d > w_acc_b_d && w_acc_r_d >= MinCnt) begin
      w_dom = 2'd1;
    end else if (w_acc_g_d > w_acc_r_d && w_acc_g_d > w_acc_b_d && w_acc_g_d >= MinCnt) begin
      w_dom = 2'd2;
    end else if (w_acc_b_d > w_acc_r_d && w_acc_b_d > w_acc_g_d && w_acc_b_d >= MinCnt) begin
      w_dom = 2'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= (r_state == S_SCAN);
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_drain <= '0;
      r_acc_r <= '0;
      r_acc_g <= '0;
      r_acc_b <= '0;
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
      r_dom   <= '0;
    end else begin
      r_acc_r <= w_acc_r_d;
      r_acc_g <= w_acc_g_d;
      r_acc_b <= w_acc_b_d;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          if (bus.start) begin
            r_state <= S_SCAN;
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
          end
        end
        S_SCAN: begin
          if (r_addr == LastAddr) begin
            r_addr  <= '0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
          // Last pixel lands this cycle, so publish the post-update totals.
          if (r_drain == LastDrn) begin
            r_state <= S_DONE;
            r_cnt_r <= w_acc_r_d;
            r_cnt_g <= w_acc_g_d;
            r_cnt_b <= w_acc_b_d;
            r_dom   <= w_dom;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.mem_addr    = r_addr;
  assign bus.count_red   = r_cnt_r;
  assign bus.count_green = r_cnt_g;
  assign bus.count_blue  = r_cnt_b;
  assign bus.dominant    = r_dom;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Bench for frame_scan_ctrl on a reduced 32x24 frame with a 2-cycle RAM, checked against a
// per-pixel reference model of the classification and dominance rules.
module tb_frame_scan_ctrl;
  localparam int X      = 32;
  localparam int Y      = 24;
  localparam int N      = X * Y;
  localparam int AW     = 15;
  localparam int DW     = 12;
  localparam int RD_LAT = 2;
  localparam int TH     = 2;
  localparam int MINC   = 64;
  localparam int L      = N + RD_LAT + 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_scan_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  frame_scan_ctrl #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(DW),
    .RD_LAT(RD_LAT), .TH(TH), .MIN_COUNT(MINC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [11:0] mem [0:N-1];
  logic [11:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[int'(bus.mem_addr) % N];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_data = rd_pipe[RD_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of one run_scan call, indexed by cycle (start sampled at cycle 0).
  int start_q[$];
  int rst_cyc;
  bit busy_log [0:L];
  int addr_log [0:L];
  int done_n, done_cyc;
  int cap_r, cap_g, cap_b, cap_d;

  task automatic model(output int er, output int eg, output int eb, output int ed);
    int r, g, b;
    er = 0; eg = 0; eb = 0;
    for (int i = 0; i < N; i++) begin
      r = int'(mem[i][11:8]); g = int'(mem[i][7:4]); b = int'(mem[i][3:0]);
      if (r > g + TH && r > b + TH) er++;
      else if (g > r + TH && g > b + TH) eg++;
      else if (b > r + TH && b > g + TH) eb++;
    end
    if (er > eg && er > eb && er >= MINC) ed = 1;
    else if (eg > er && eg > eb && eg >= MINC) ed = 2;
    else if (eb > er && eb > eg && eb >= MINC) ed = 3;
    else ed = 0;
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_scan();
    done_n = 0; done_cyc = -1;
    cap_r = -1; cap_g = -1; cap_b = -1; cap_d = -1;
    for (int c = 0; c <= L; c++) begin
      busy_log[c] = bus.busy;
      addr_log[c] = int'(bus.mem_addr);
      if (bus.done) begin
        if (done_n == 0) begin
          done_cyc = c;
          cap_r = int'(bus.count_red); cap_g = int'(bus.count_green);
          cap_b = int'(bus.count_blue); cap_d = int'(bus.dominant);
        end
        done_n++;
      end
      bus.start = (c == 0);
      foreach (start_q[i]) if (start_q[i] == c) bus.start = 1'b1;
      rst = (c == rst_cyc);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    start_q.delete();
    rst_cyc = -1;
  endtask

  task automatic check_scan(input string name);
    int er, eg, eb, ed;
    model(er, eg, eb, ed);
    n_cmp += 7;
    if (done_cyc !== N + RD_LAT + 1) begin
      n_bad++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, N + RD_LAT + 1);
    end
    if (done_n !== 1) begin n_bad++; $display("FAIL %s done_pulses got %0d want 1", name, done_n); end
    if (cap_r !== er) begin n_bad++; $display("FAIL %s count_red got %0d want %0d", name, cap_r, er); end
    if (cap_g !== eg) begin n_bad++; $display("FAIL %s count_green got %0d want %0d", name, cap_g, eg); end
    if (cap_b !== eb) begin n_bad++; $display("FAIL %s count_blue got %0d want %0d", name, cap_b, eb); end
    if (cap_d !== ed) begin n_bad++; $display("FAIL %s dominant got %0d want %0d", name, cap_d, ed); end
    if (int'(bus.count_red) !== er || int'(bus.dominant) !== ed) begin
      n_bad++; $display("FAIL %s held_outputs got r=%0d d=%0d want r=%0d d=%0d", name,
                        bus.count_red, bus.dominant, er, ed);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 4;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b want 0", bus.done); end
    if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL reset mem_addr got %0d want 0", bus.mem_addr); end
    if (bus.count_red !== '0 || bus.count_green !== '0 || bus.count_blue !== '0 || bus.dominant !== 2'd0) begin
      n_bad++; $display("FAIL reset results got %0d/%0d/%0d d=%0d want 0/0/0 d=0",
                        bus.count_red, bus.count_green, bus.count_blue, bus.dominant);
    end
  endtask

  task automatic test_solid_red();
    do_reset();
    fill(12'hF00);
    run_scan();
    n_cmp += 3;
    if (busy_log[1] !== 1'b1) begin n_bad++; $display("FAIL red busy_c1 got %b want 1", busy_log[1]); end
    if (addr_log[1] !== 0) begin n_bad++; $display("FAIL red addr_c1 got %0d want 0", addr_log[1]); end
    if (addr_log[N] !== N - 1) begin n_bad++; $display("FAIL red addr_cN got %0d want %0d", addr_log[N], N - 1); end
    check_scan("solid_red");
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < N; i++) mem[i] = (i < N / 2) ? 12'h0F0 : 12'h00F;
    run_scan();
    check_scan("green_blue_tie");
  endtask

  task automatic test_threshold();
    do_reset();
    fill(12'h520);
    run_scan();
    check_scan("margin_plus1");
    fill(12'h530);
    run_scan();
    check_scan("margin_equal");
  endtask

  task automatic test_min_count();
    do_reset();
    fill(12'h888);
    for (int i = 0; i < 40; i++) mem[i * 7] = 12'h00F;
    run_scan();
    check_scan("below_min_count");
  endtask

  task automatic test_random();
    logic [11:0] pal [0:5];
    pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F;
    pal[3] = 12'h888; pal[4] = 12'h520; pal[5] = 12'h530;
    do_reset();
    for (int i = 0; i < N; i++) mem[i] = 12'($urandom);
    run_scan();
    check_scan("random_pixels");
    for (int i = 0; i < N; i++) mem[i] = pal[$urandom_range(5, 0)];
    run_scan();
    check_scan("random_palette");
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(12'hF00);
    start_q.push_back(5);
    start_q.push_back(N + 1);
    start_q.push_back(N + RD_LAT + 1);
    start_q.push_back(N + RD_LAT + 2);
    run_scan();
    n_cmp += 2;
    if (busy_log[N + RD_LAT + 2] !== 1'b0) begin
      n_bad++; $display("FAIL restart busy_idle got %b want 0", busy_log[N + RD_LAT + 2]);
    end
    if (busy_log[N + RD_LAT + 3] !== 1'b1) begin
      n_bad++; $display("FAIL restart busy_rise got %b want 1", busy_log[N + RD_LAT + 3]);
    end
    check_scan("extra_starts");
  endtask

  task automatic test_abort();
    do_reset();
    fill(12'h0F0);
    rst_cyc = N / 2;
    run_scan();
    n_cmp += 4;
    if (busy_log[N / 2 + 1] !== 1'b0) begin
      n_bad++; $display("FAIL abort busy got %b want 0", busy_log[N / 2 + 1]);
    end
    if (addr_log[N / 2 + 1] !== 0) begin
      n_bad++; $display("FAIL abort mem_addr got %0d want 0", addr_log[N / 2 + 1]);
    end
    if (done_n !== 0) begin n_bad++; $display("FAIL abort done_pulses got %0d want 0", done_n); end
    if (bus.count_green !== '0 || bus.dominant !== 2'd0) begin
      n_bad++; $display("FAIL abort results got g=%0d d=%0d want 0", bus.count_green, bus.dominant);
    end
    run_scan();
    check_scan("after_abort");
  endtask

  initial begin
    bus.start = 1'b0;
    rst_cyc = -1;
    fill(12'h000);
    test_reset();
    test_solid_red();
    test_tie();
    test_threshold();
    test_min_count();
    test_random();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
